// File: rtl/mem_arb.sv
// Two-port memory arbiter: IFU and LSU share one memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed LSU priority.
module mem_arb #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_ifu_req,
    input  logic [AW-1:0]   i_ifu_addr,
    output logic            o_ifu_gnt,
    output logic            o_ifu_rvalid,
    output logic [DW-1:0]   o_ifu_rdata,

    input  logic            i_lsu_req,
    input  logic            i_lsu_we,
    input  logic [AW-1:0]   i_lsu_addr,
    input  logic [DW-1:0]   i_lsu_wdata,
    input  logic [DW/8-1:0] i_lsu_wmask,
    output logic            o_lsu_gnt,
    output logic            o_lsu_rvalid,
    output logic [DW-1:0]   o_lsu_rdata,

    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wmask,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata,

    output logic            o_err
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e            state_q;
    logic              owner_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW/8-1:0]   wmask_q;
    logic [DW-1:0]     ifu_rdata_q;
    logic [DW-1:0]     lsu_rdata_q;

    logic              any_req;
    logic              pick_lsu;
    logic              arb_en;
    logic              busy;
    logic              timeout;
    logic              resp_load;
    logic [DW-1:0]     resp_data;

    assign any_req = i_ifu_req | i_lsu_req;

`ifdef MEM_ARB_RR_EN
    logic last_lsu_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_lsu_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            last_lsu_q <= pick_lsu;
        end
    end

    // On contention the requester that was not served last wins.
    assign pick_lsu = i_lsu_req & (~i_ifu_req | ~last_lsu_q);
`else
    assign pick_lsu = i_lsu_req;
`endif

    // Reset gates the grant so no gnt escapes while i_rst is low.
    assign arb_en    = (state_q == StIdle) & i_rst;
    assign busy      = (state_q == StReq) | (state_q == StWait);
    assign timeout   = busy & (cnt_q == CW'(TIMEOUT));
    assign resp_load = timeout | ((state_q == StWait) & i_mem_rvalid);
    assign resp_data = timeout ? '0 : i_mem_rdata;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q <= pick_lsu;
                        we_q    <= pick_lsu & i_lsu_we;
                        addr_q  <= pick_lsu ? i_lsu_addr : i_ifu_addr;
                        wdata_q <= pick_lsu ? i_lsu_wdata : '0;
                        wmask_q <= pick_lsu ? i_lsu_wmask : '0;
                        cnt_q   <= '0;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (timeout) begin
                        state_q <= StResp;
                    end else if (i_mem_gnt) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (timeout || i_mem_rvalid) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (resp_load) begin
                if (owner_q) begin
                    lsu_rdata_q <= resp_data;
                end else begin
                    ifu_rdata_q <= resp_data;
                end
            end
        end
    end

    assign o_ifu_gnt    = arb_en & i_ifu_req & ~pick_lsu;
    assign o_lsu_gnt    = arb_en & pick_lsu;
    assign o_ifu_rvalid = (state_q == StResp) & ~owner_q;
    assign o_lsu_rvalid = (state_q == StResp) & owner_q;
    assign o_ifu_rdata  = ifu_rdata_q;
    assign o_lsu_rdata  = lsu_rdata_q;

    assign o_mem_req    = (state_q == StReq);
    assign o_mem_we     = o_mem_req & we_q;
    assign o_mem_addr   = o_mem_req ? addr_q  : '0;
    assign o_mem_wdata  = o_mem_req ? wdata_q : '0;
    assign o_mem_wmask  = o_mem_req ? wmask_q : '0;

    assign o_err        = timeout;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, 32, address width.
REQ-002 SHALL have parameter DW, 32, data width.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum cycles a transaction waits in REQ plus WAIT before it is aborted.
REQ-004 SHALL have port i_clk, in, 1, single clock; all state on the rising edge.
REQ-005 SHALL have port i_rst, in, 1, asynchronous active-low reset.
REQ-006 SHALL have fetch ports i_ifu_req in 1, i_ifu_addr in AW, o_ifu_gnt out 1, o_ifu_rvalid out 1, o_ifu_rdata out DW.
REQ-007 SHALL have load/store ports i_lsu_req in 1, i_lsu_we in 1, i_lsu_addr in AW, i_lsu_wdata in DW, i_lsu_wmask in DW/8, o_lsu_gnt out 1, o_lsu_rvalid out 1, o_lsu_rdata out DW.
REQ-008 SHALL have memory ports o_mem_req out 1, o_mem_we out 1, o_mem_addr out AW, o_mem_wdata out DW, o_mem_wmask out DW/8, i_mem_gnt in 1, i_mem_rvalid in 1, i_mem_rdata in DW.
REQ-009 SHALL have port o_err, out, 1, one-cycle pulse on transaction timeout.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT and RESP, with a 1-bit owner register (0 = IFU, 1 = LSU).
REQ-011 In IDLE with any request pending, SHALL pulse the winner's gnt for that cycle, latch its we/addr/wdata/wmask (we forced 0 for IFU), set owner and go to REQ next cycle.
REQ-012 Default arbitration SHALL be fixed priority, with LSU winning over IFU when both requests are high.
REQ-013 In REQ, SHALL hold o_mem_req=1 with the latched fields stable until i_mem_gnt=1, then go to WAIT.
REQ-014 In WAIT, on i_mem_rvalid=1, SHALL register i_mem_rdata into the owner's rdata and go to RESP.
REQ-015 In RESP, SHALL assert the owner's rvalid for exactly one cycle, then go to IDLE; new arbitration happens no earlier than the next IDLE cycle.
REQ-016 Minimum latency SHALL be: gnt at cycle t, o_mem_req at t+1, rvalid at t+3 when i_mem_gnt is at t+1 and i_mem_rvalid at t+2.
REQ-017 Writes SHALL complete the same way; rdata carries i_mem_rdata unmodified.
REQ-018 i_mem_rvalid or i_mem_gnt seen in IDLE or RESP SHALL be ignored.
REQ-019 A cycle counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; at count == TIMEOUT, the block SHALL pulse o_err, load 0 into the owner's rdata and go to RESP.
REQ-020 Each rdata output SHALL hold its value until the next response to that owner.
REQ-021 The non-owner's gnt and rvalid SHALL stay 0 throughout a transaction.
REQ-022 o_mem_we/addr/wdata/wmask SHALL be 0 whenever o_mem_req=0.

Reset
REQ-023 i_rst=0 SHALL asynchronously force IDLE, owner=0, counter=0, all outputs 0 and both rdata registers 0.
REQ-024 Reset during REQ, WAIT or RESP SHALL discard the transaction with no rvalid; a stale i_mem_rvalid after reset release SHALL be ignored.
REQ-025 The first arbitration SHALL occur in the first cycle after reset deassertion that has a request high.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, a last-served register (reset to IFU) SHALL be kept; when both requests are high, the requester other than last-served wins. A single requester always wins.
REQ-027 Without MEM_ARB_RR_EN, there SHALL be fixed LSU priority and no last-served register.

Verification
REQ-028 Single IFU fetch: i_ifu_req=1, addr=0x80000000; memory gnt immediate, rvalid next cycle, rdata=0x00000413 -> o_ifu_gnt at t, o_mem_req t+1, o_ifu_rvalid t+3, o_ifu_rdata=0x00000413.
REQ-029 Simultaneous requests, IFU addr 0x80000004 and LSU read 0x80001000 -> without RR_EN, LSU served first and IFU after RESP; with RR_EN after reset, LSU first, then on repeat IFU first.
REQ-030 LSU write: we=1, addr=0x80002000, wdata=0xDEADBEEF, wmask=0xF; i_mem_gnt delayed 3 cycles -> o_mem_* fields stable all 4 REQ cycles, o_lsu_rvalid once, o_ifu_* idle.
REQ-031 Timeout with TIMEOUT=8: memory never asserts rvalid -> o_err pulse 8 cycles after REQ entry, owner rvalid with rdata=0, then IDLE.
REQ-032 Reset asserted in WAIT, with i_mem_rvalid=1 one cycle after release -> all outputs 0 during reset, no rvalid generated, FSM in IDLE.
